ifetch_unit: RTL

//  Instruction fetch front-end: the requester side of the instruction ROM port.

---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/ifetch_sync_fifo.sv | 76 +++++++
 rtl/ifetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: default geometry, fetch-entry width ({pc, inst}), clog2 helper.
package ifetch_pkg;

    localparam int DWIDTH_DEF     = 16;
    localparam int AWIDTH_DEF     = 12;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int RESET_PC_DEF   = 0;

    // A buffered fetch entry is {pc, inst}, pc in the upper bits.
    function automatic int entry_width(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ifetch_sync_fifo.sv
// Synchronous FIFO with push/pop/flush; flush overrides push and pop.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push into a full FIFO is ignored unless a pop happens the same cycle.
// Ports: clk, rst (sync, active-high), push_i/push_dat_i, pop_i, flush_i,
//        head_dat_o (entry at head), count_o, full_o, empty_o.
module sync_fifo
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [clog2(DEPTH):0]    count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: issues ROM reads, buffers responses, hands {pc, inst} to decode.
// Latency: rom_ready to inst_valid is 2 cycles (1 ROM + 1 FIFO, no bypass).
// Backpressure: credit (buffered + in-flight < FIFO_DEPTH) gates rom_ready; inst_ready pops.
// Ports: clk, rst; ROM side rom_addr/rom_ready/rom_dout/rom_valid; redirect_valid/redirect_pc;
//        decode side inst_valid/inst_ready/inst_data/inst_pc.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int RESET_PC   = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] rom_addr,
    output logic              rom_ready,
    input  logic [DWIDTH-1:0] rom_dout,
    input  logic              rom_valid,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DWIDTH-1:0] inst_data,
    output logic [AWIDTH-1:0] inst_pc
);

    localparam int                CW      = clog2(FIFO_DEPTH) + 1;
    localparam int                EW      = entry_width(AWIDTH, DWIDTH);
    localparam logic [AWIDTH-1:0] PC_RST  = AWIDTH'(RESET_PC);
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_head;
    logic [CW:0]       credit_used;
    logic              issue, push, pop;

    // Reserve a slot for the outstanding read so its response can never overflow.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue       = !rst && !redirect_valid && (credit_used < DEPTH_C);

    assign rom_ready  = issue;
    assign rom_addr   = pc_q;
    assign inst_valid = !rst && !fifo_empty;
    assign pop        = inst_valid && inst_ready;
    // Responses with no read outstanding, or killed by a redirect, are discarded.
    assign push       = rom_valid && inflight_q && !drop_q && (!fifo_full || pop);
    assign {inst_pc, inst_data} = fifo_head;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        drop_d     = 1'b0;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            drop_d = inflight_q;
        end else if (issue) begin
            pc_d       = pc_q + 1'b1;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= PC_RST;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i ({req_pc_q, rom_dout}),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule
